// File: rtl/fb_read_arbiter.sv
// Frame-buffer read-port arbiter: VGA owns every active cycle, aux is served in blanking with a forced idle slot after AUX_BURST grants.
// Data returns 1+RD_LAT+1 clocks after grant on its requester's rvalid; aux holds req until aux_gnt. Optional FB_ARB_STATS_EN adds per-frame aux counters.
module fb_read_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 12,
  parameter int RD_LAT    = 2,
  parameter int AUX_BURST = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_vga_en,
  input  logic [ADDR_W-1:0] i_vga_addr,
  output logic [DATA_W-1:0] o_vga_rdata,
  output logic              o_vga_rvalid,
  input  logic              i_aux_req,
  input  logic [ADDR_W-1:0] i_aux_addr,
  output logic              o_aux_gnt,
  output logic [DATA_W-1:0] o_aux_rdata,
  output logic              o_aux_rvalid,
  input  logic              i_frame_sync,
  output logic [ADDR_W-1:0] o_fb_rdaddress,
  input  logic [DATA_W-1:0] i_fb_q,
  output logic [1:0]        o_owner
`ifdef FB_ARB_STATS_EN
  ,
  output logic [16:0]       o_aux_grants_last,
  output logic [16:0]       o_aux_stall_last
`endif
);

  localparam logic [1:0] SLOT_IDLE = 2'd0;
  localparam logic [1:0] SLOT_VGA  = 2'd1;
  localparam logic [1:0] SLOT_AUX  = 2'd2;
  localparam int         BC_W      = $clog2(AUX_BURST + 1);
  localparam logic [BC_W-1:0] BURST_MAX = BC_W'(AUX_BURST);

  logic [1:0]        r_owner;
  logic [1:0]        w_owner_nxt;
  logic [BC_W-1:0]   r_burst_cnt;
  logic              w_burst_ok;
  logic              w_aux_gnt;
  logic [ADDR_W-1:0] r_fb_rdaddress;
  logic [1:0]        r_tag [RD_LAT+1];
  logic              r_vga_rvalid;
  logic              r_aux_rvalid;
  logic [DATA_W-1:0] r_vga_rdata;
  logic [DATA_W-1:0] r_aux_rdata;

  assign w_burst_ok = (r_burst_cnt < BURST_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner <= SLOT_IDLE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // Slot choice depends only on this cycle's requests; owner just records it.
  always_comb begin
    w_owner_nxt = SLOT_IDLE;
    if (i_vga_en) begin
      w_owner_nxt = SLOT_VGA;
    end else if (i_aux_req && w_burst_ok) begin
      w_owner_nxt = SLOT_AUX;
    end
  end

  always_comb begin
    w_aux_gnt = 1'b0;
    if (w_owner_nxt == SLOT_AUX) begin
      w_aux_gnt = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fb_rdaddress <= '0;
      r_burst_cnt    <= '0;
    end else begin
      if (w_owner_nxt == SLOT_VGA) begin
        r_fb_rdaddress <= i_vga_addr;
      end else if (w_owner_nxt == SLOT_AUX) begin
        r_fb_rdaddress <= i_aux_addr;
      end
      // Cannot pass BURST_MAX: a full counter blocks the grant and clears on the idle slot.
      if (w_aux_gnt) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end else begin
        r_burst_cnt <= '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        r_tag[i] <= SLOT_IDLE;
      end
      r_vga_rvalid <= 1'b0;
      r_aux_rvalid <= 1'b0;
      r_vga_rdata  <= '0;
      r_aux_rdata  <= '0;
    end else begin
      r_tag[0] <= w_owner_nxt;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
      r_vga_rvalid <= (r_tag[RD_LAT] == SLOT_VGA);
      r_aux_rvalid <= (r_tag[RD_LAT] == SLOT_AUX);
      if (r_tag[RD_LAT] == SLOT_VGA) begin
        r_vga_rdata <= i_fb_q;
      end
      if (r_tag[RD_LAT] == SLOT_AUX) begin
        r_aux_rdata <= i_fb_q;
      end
    end
  end

  assign o_owner        = r_owner;
  assign o_aux_gnt      = w_aux_gnt;
  assign o_fb_rdaddress = r_fb_rdaddress;
  assign o_vga_rvalid   = r_vga_rvalid;
  assign o_vga_rdata    = r_vga_rdata;
  assign o_aux_rvalid   = r_aux_rvalid;
  assign o_aux_rdata    = r_aux_rdata;

`ifdef FB_ARB_STATS_EN
  logic        r_fs_d;
  logic        w_fs_fall;
  logic        w_stall;
  logic [16:0] r_grant_live;
  logic [16:0] r_stall_live;
  logic [16:0] r_grants_last;
  logic [16:0] r_stall_last;

  assign w_fs_fall = r_fs_d & ~i_frame_sync;
  assign w_stall   = i_aux_req & ~w_aux_gnt;

  // The edge cycle's own events belong to the new frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fs_d        <= 1'b1;
      r_grant_live  <= '0;
      r_stall_live  <= '0;
      r_grants_last <= '0;
      r_stall_last  <= '0;
    end else begin
      r_fs_d <= i_frame_sync;
      if (w_fs_fall) begin
        r_grants_last <= r_grant_live;
        r_stall_last  <= r_stall_live;
        r_grant_live  <= {16'd0, w_aux_gnt};
        r_stall_live  <= {16'd0, w_stall};
      end else begin
        if (w_aux_gnt && (r_grant_live != '1)) begin
          r_grant_live <= r_grant_live + 1'b1;
        end
        if (w_stall && (r_stall_live != '1)) begin
          r_stall_live <= r_stall_live + 1'b1;
        end
      end
    end
  end

  assign o_aux_grants_last = r_grants_last;
  assign o_aux_stall_last  = r_stall_last;
`else
  logic w_unused_frame_sync;
  assign w_unused_frame_sync = i_frame_sync;
`endif

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Directed bench for fb_read_arbiter with a 2-clock RAM model and a cycle-level reference of slot/return behaviour.
module tb_fb_read_arbiter;
  localparam int AUX_BURST = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vga_en = 1'b0;
  logic        aux_req = 1'b0;
  logic        frame_sync = 1'b1;
  logic [16:0] vga_addr = '0;
  logic [16:0] aux_addr = '0;
  logic [11:0] q1;
  logic [11:0] fb_q;
  logic [11:0] vga_rdata, aux_rdata;
  logic        vga_rvalid, aux_rvalid, aux_gnt;
  logic [16:0] fb_rdaddress;
  logic [1:0]  owner;
`ifdef FB_ARB_STATS_EN
  logic [16:0] aux_grants_last, aux_stall_last;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #20 clk = ~clk;

  function automatic logic [11:0] ram(input logic [16:0] a);
    return a[11:0] ^ {7'd0, a[16:12]};
  endfunction

  always @(posedge clk) begin
    q1   <= ram(fb_rdaddress);
    fb_q <= q1;
  end

  fb_read_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_vga_en(vga_en), .i_vga_addr(vga_addr),
    .o_vga_rdata(vga_rdata), .o_vga_rvalid(vga_rvalid),
    .i_aux_req(aux_req), .i_aux_addr(aux_addr), .o_aux_gnt(aux_gnt),
    .o_aux_rdata(aux_rdata), .o_aux_rvalid(aux_rvalid),
    .i_frame_sync(frame_sync), .o_fb_rdaddress(fb_rdaddress),
    .i_fb_q(fb_q), .o_owner(owner)
`ifdef FB_ARB_STATS_EN
    , .o_aux_grants_last(aux_grants_last), .o_aux_stall_last(aux_stall_last)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: per-cycle slot rule plus a return schedule 4 cycles out.
  logic [1:0]  m_kind [8];
  logic [11:0] m_data [8];
  logic [16:0] m_addr;
  logic [1:0]  m_owner;
  logic [11:0] m_vga_last, m_aux_last;
  int          m_run;
  int          cyc;
  initial begin
    logic [1:0] k;
    int s;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_fb_rdaddress", fb_rdaddress, 0);
        chk("rst_owner", owner, 0);
        chk("rst_vga_rvalid", vga_rvalid, 0);
        chk("rst_aux_rvalid", aux_rvalid, 0);
        chk("rst_rdata", {vga_rdata, aux_rdata}, 0);
        for (int i = 0; i < 8; i++) m_kind[i] = 2'd0;
        m_addr = '0; m_owner = 2'd0; m_run = 0; cyc = 0;
        m_vga_last = '0; m_aux_last = '0;
      end else begin
        s = cyc % 8;
        if (m_kind[s] == 2'd1) m_vga_last = m_data[s];
        if (m_kind[s] == 2'd2) m_aux_last = m_data[s];
        chk("m_vga_rvalid", vga_rvalid, m_kind[s] == 2'd1);
        chk("m_aux_rvalid", aux_rvalid, m_kind[s] == 2'd2);
        chk("m_vga_rdata", vga_rdata, m_vga_last);
        chk("m_aux_rdata", aux_rdata, m_aux_last);
        chk("m_fb_rdaddress", fb_rdaddress, m_addr);
        chk("m_owner", owner, m_owner);
        m_kind[s] = 2'd0;
        k = vga_en ? 2'd1 : ((aux_req && m_run < AUX_BURST) ? 2'd2 : 2'd0);
        chk("m_aux_gnt", aux_gnt, k == 2'd2);
        m_owner = k;
        if (k == 2'd1) m_addr = vga_addr;
        if (k == 2'd2) m_addr = aux_addr;
        m_run = (k == 2'd2) ? m_run + 1 : 0;
        m_kind[(cyc + 4) % 8] = k;
        m_data[(cyc + 4) % 8] = ram(m_addr);
        cyc++;
      end
    end
  end

  initial begin
    int grants, rv, run, max_run;
    logic g;
    repeat (3) step();
    rst_n = 1'b1;

    // VGA stream 0,1,2,...
    vga_en = 1'b1;
    vga_addr = 17'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("vga_no_aux_gnt", aux_gnt, 0);
      if (i == 1) chk("vga_fb_addr_1", fb_rdaddress, 17'd0);
      if (i == 2) chk("vga_fb_addr_2", fb_rdaddress, 17'd1);
      if (i == 3) chk("vga_rvalid_early", vga_rvalid, 0);
      if (i == 4) chk("vga_first_rvalid", {vga_rvalid, vga_rdata}, {1'b1, 12'h000});
      if (i == 5) chk("vga_second_rdata", {vga_rvalid, vga_rdata}, {1'b1, 12'h001});
      step();
      vga_addr = 17'(i + 1);
    end
    vga_en = 1'b0;
    repeat (6) step();

    // Single aux read in blanking
    aux_req = 1'b1;
    aux_addr = 17'h1ABCD;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) chk("aux_gnt_same_cycle", aux_gnt, 1);
      if (i == 1) chk("aux_owner_addr", {owner, fb_rdaddress}, {2'd2, 17'h1ABCD});
      if (i == 3) chk("aux_rvalid_early", aux_rvalid, 0);
      if (i == 4) chk("aux_return", {aux_rvalid, aux_rdata}, {1'b1, 12'hBD7});
      step();
      aux_req = 1'b0;
    end
    repeat (4) step();

    // VGA pre-empts a held aux request at K = j 3
    aux_req = 1'b1;
    aux_addr = 17'h00500;
    for (int j = 0; j < 10; j++) begin
      if (j == 3) begin vga_en = 1'b1; vga_addr = 17'h00777; end
      @(negedge clk);
      if (j == 3) chk("preempt_gnt_low", aux_gnt, 0);
      if (j == 4) chk("preempt_issue", {owner, fb_rdaddress}, {2'd1, 17'h00777});
      if (j == 6) chk("preempt_aux_drain", {aux_rvalid, vga_rvalid, aux_rdata}, {2'b10, 12'h500});
      if (j == 7) chk("preempt_vga_ret", {aux_rvalid, vga_rvalid, vga_rdata}, {2'b01, 12'h777});
      step();
    end
    vga_en = 1'b0;
    aux_req = 1'b0;
    repeat (6) step();

    // Burst limit: 200 cycles of held aux request
    grants = 0; rv = 0; run = 0; max_run = 0;
    aux_addr = 17'h02000;
    for (int i = 0; i < 206; i++) begin
      aux_req = (i < 200);
      @(negedge clk);
      g = aux_gnt;
      if (g) begin grants++; run++; end else run = 0;
      if (run > max_run) max_run = run;
      if (aux_rvalid) rv++;
      if (i == 64 || i == 129 || i == 194) chk("burst_idle_slot", g, 0);
      step();
      if (g) aux_addr = aux_addr + 17'd1;
    end
    chk("burst_grants", grants, 197);
    chk("burst_max_run", max_run, 64);
    chk("burst_rvalids", rv, 197);
    repeat (2) step();

    // Reset with aux reads in flight
    aux_req = 1'b1;
    aux_addr = 17'h00100;
    repeat (2) begin @(negedge clk); step(); end
    rst_n = 1'b0;
    aux_req = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {vga_rvalid, aux_rvalid, aux_rdata}, 0);
      step();
    end

`ifdef FB_ARB_STATS_EN
    frame_sync = 1'b0; step();
    frame_sync = 1'b1; step();
    aux_req = 1'b1;
    repeat (10) step();
    vga_en = 1'b1;
    repeat (5) step();
    vga_en = 1'b0; aux_req = 1'b0;
    repeat (2) step();
    frame_sync = 1'b0; step();
    @(negedge clk);
    chk("stats_grants", aux_grants_last, 17'd10);
    chk("stats_stall", aux_stall_last, 17'd5);
    step();
    frame_sync = 1'b1;
    aux_req = 1'b1;
    repeat (3) step();
    aux_req = 1'b0;
    step();
    frame_sync = 1'b0; step();
    @(negedge clk);
    chk("stats_grants_restart", aux_grants_last, 17'd3);
    chk("stats_stall_restart", aux_stall_last, 17'd0);
    step();
    frame_sync = 1'b1;
    repeat (2) step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_read_arbiter.md
Name: fb_read_arbiter

Overview:
- Shares the single frame_buffer read port (rdaddress/q, 25 MHz VGA clock domain) between two requesters.
- VGA display path (Address_Generator) has absolute priority during activeArea.
- One auxiliary requester (e.g. a frame-analysis scanner feeding classification) is served only in blanking cycles.
- Routes returned pixel data back to the issuing requester using a latency-matched tag pipeline.

Parameters:
- ADDR_W, 17, frame buffer address width
- DATA_W, 12, frame buffer word width (4:4:4 RGB)
- RD_LAT, 2, frame_buffer read latency in clocks from rdaddress to q (fixed by the RAM configuration)
- AUX_BURST, 64, max consecutive aux grants before one forced idle slot

Ports:
- clk, in, 1, 25 MHz VGA clock (clk_25_vga)
- rst_n, in, 1, asynchronous active-low reset
- vga_en, in, 1, VGA read request (activeArea)
- vga_addr, in, ADDR_W, VGA read address
- vga_rdata, out, DATA_W, pixel returned to VGA/RGB path
- vga_rvalid, out, 1, vga_rdata valid
- aux_req, in, 1, aux read request; hold with aux_addr until granted
- aux_addr, in, ADDR_W, aux read address
- aux_gnt, out, 1, aux request accepted this cycle
- aux_rdata, out, DATA_W, data returned to aux
- aux_rvalid, out, 1, aux_rdata valid
- frame_sync, in, 1, VGA vsync (active-low pulse); used for per-frame bookkeeping
- fb_rdaddress, out, ADDR_W, to frame_buffer rdaddress
- fb_q, in, DATA_W, from frame_buffer q
- owner, out, 2, current slot owner: 0 IDLE, 1 VGA, 2 AUX

Behaviour:
- Reset values: fb_rdaddress=0, owner=0, all rvalid=0, rdata=0, tag pipe cleared, burst counter=0.
- Reset is asynchronous. Asserting it mid-transfer drops all in-flight reads; no rvalid is produced for them after release.
- Slot decision is made each cycle.
  - vga_en=1: VGA slot.
  - else aux_req=1 and burst_cnt<AUX_BURST: AUX slot.
  - else: IDLE slot.
- aux_gnt is combinational: aux_req & ~vga_en & (burst_cnt<AUX_BURST). A VGA request pre-empts aux in the same cycle it rises. The aux request must stay held, unchanged, until granted.
- Issue: the winning address is registered onto fb_rdaddress at the next edge. An IDLE slot holds the previous fb_rdaddress.
- State register `owner` takes the slot type at the same edge. Transitions:
  - IDLE->VGA or IDLE->AUX on request.
  - VGA->AUX allowed on the cycle after vga_en falls.
  - AUX->VGA immediate.
  - AUX->IDLE when aux_req drops or the burst limit is hit.
- Tag pipe: a 2-bit tag per slot (IDLE/VGA/AUX), depth 1+RD_LAT. A request issued at cycle N returns at cycle N+1+RD_LAT (default N+3).
  - Returning tag VGA: vga_rvalid=1 and vga_rdata=fb_q, registered.
  - Returning tag AUX: aux_rvalid=1 and aux_rdata=fb_q, registered.
  - Total request-to-rvalid latency is 1+RD_LAT+1 = 4 cycles (default).
  - Returned data is exactly one rdata word per grant, in issue order. Never both rvalid in one cycle.
- rdata is held between valids (not zeroed).
- burst_cnt:
  - Increments on each aux grant, saturating at AUX_BURST.
  - Clears on any non-AUX slot.
  - On reaching AUX_BURST, exactly one IDLE slot is forced, then the counter clears.
- Simultaneous vga_en and aux_req: VGA wins, aux_gnt=0, burst_cnt clears.
- Address wrap is not performed here. Addresses pass through unchanged.

Optional Feature:
- Macro: FB_ARB_STATS_EN.
- When defined, adds outputs:
  - aux_grants_last, 17 bits: aux grants in the previous frame.
  - aux_stall_last, 17 bits: cycles with aux_req=1 & aux_gnt=0 in the previous frame.
- Both live counters saturate. On the frame_sync falling edge (registered edge detect), the live counts latch into the *_last outputs and the live counters clear.
- Reset clears all stats registers.
- When not defined: no stats ports or logic, and frame_sync is unused.

Test Plan:
- Reset release, vga_en=1 with vga_addr=0,1,2...: fb_rdaddress follows with 1-cycle delay. vga_rvalid rises 4 cycles after the first request, with vga_rdata=fb_q of the matching address. aux_gnt stays 0 throughout.
- Blanking, aux_req=1 at addr 0x1ABCD held: aux_gnt=1 in the same cycle. aux_rvalid=1 four cycles later with aux_rdata=RAM[0x1ABCD]. owner=2.
- aux_req held while vga_en rises on cycle K: aux_gnt=0 at cycle K, and the VGA address is issued at K+1. In-flight aux data from K-1 still returns on aux_rvalid at K+3. vga_rvalid starts at K+4, with no overlap.
- aux_req held for 200 blanking cycles with AUX_BURST=64: a grant pattern of 64 on, 1 off, repeating. Exactly 64 aux_rvalid per run.
- Assert rst_n=0 with 2 aux reads in flight, then release: no aux_rvalid or vga_rvalid after release until new grants. All outputs at reset values.
- With FB_ARB_STATS_EN: a frame with 10 aux grants and 5 stall cycles, then a frame_sync falling edge. aux_grants_last=10 and aux_stall_last=5 on the next cycle, and the live counters restart from 0.
